// File: rtl/alu_writeback.sv
//------------------------------------------------------------------------------
// Module  : alu_writeback
// Brief   : One-entry ALU writeback register that commits into a register file
//           and flag register, with bypassed combinational operand read ports.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_writeback #(
   parameter int W    = 8,
   parameter int NREG = 8,
   parameter int AW   = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_result,
   input  logic          in_zero,
   input  logic          in_sign,
   input  logic [AW-1:0] in_rd,
   input  logic          in_wen,
   input  logic          in_flag_en,
   input  logic          hold,
   input  logic [AW-1:0] ra_addr,
   input  logic [AW-1:0] rb_addr,
   output logic [W-1:0]  ra_data,
   output logic [W-1:0]  rb_data,
   output logic          zero_flag,
   output logic          sign_flag,
   output logic          wb_valid,
   output logic [15:0]   retire_cnt
);

   logic [W-1:0]  r_regs [NREG];
   logic [W-1:0]  r_wb_result;
   logic          r_wb_zero;
   logic          r_wb_sign;
   logic [AW-1:0] r_wb_rd;
   logic          r_wb_wen;
   logic          r_wb_flag_en;
   logic          r_wb_valid;
   logic          r_zero;
   logic          r_sign;
   logic [15:0]   r_retire_cnt;

   logic          w_accept;
   logic          w_commit;
   logic          w_ready;

   assign w_ready  = ~r_wb_valid | ~hold;
   assign w_accept = in_valid & w_ready;
   assign w_commit = r_wb_valid & ~hold;

   // Writeback register: a commit and a new accept may share the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb_valid   <= 1'b0;
         r_wb_result  <= '0;
         r_wb_zero    <= 1'b0;
         r_wb_sign    <= 1'b0;
         r_wb_rd      <= '0;
         r_wb_wen     <= 1'b0;
         r_wb_flag_en <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wb_valid   <= 1'b1;
            r_wb_result  <= in_result;
            r_wb_zero    <= in_zero;
            r_wb_sign    <= in_sign;
            r_wb_rd      <= in_rd;
            r_wb_wen     <= in_wen;
            r_wb_flag_en <= in_flag_en;
         end else if (w_commit) begin
            r_wb_valid   <= 1'b0;
         end
      end
   end

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_commit && r_wb_wen && (r_wb_rd != '0)) begin
         r_regs[r_wb_rd] <= r_wb_result;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_zero       <= 1'b0;
         r_sign       <= 1'b0;
         r_retire_cnt <= '0;
      end else if (w_commit) begin
         r_retire_cnt <= r_retire_cnt + 16'd1;
         if (r_wb_flag_en) begin
            r_zero <= r_wb_zero;
            r_sign <= r_wb_sign;
         end
      end
   end

   function automatic logic [W-1:0] f_read(input logic [AW-1:0] addr);
      logic [W-1:0] v;
      v = '0;
      if (addr != '0) begin
         if (r_wb_valid && r_wb_wen && (r_wb_rd == addr)) begin
            v = r_wb_result;
         end else begin
            v = r_regs[addr];
         end
      end
      return v;
   endfunction

   assign ra_data    = f_read(ra_addr);
   assign rb_data    = f_read(rb_addr);
   assign in_ready   = w_ready;
   assign zero_flag  = r_zero;
   assign sign_flag  = r_sign;
   assign wb_valid   = r_wb_valid;
   assign retire_cnt = r_retire_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_writeback.sv
//------------------------------------------------------------------------------
// Module  : tb_alu_writeback
// Brief   : Directed vector bench for alu_writeback.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_writeback;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_result;
   logic        in_zero;
   logic        in_sign;
   logic [2:0]  in_rd;
   logic        in_wen;
   logic        in_flag_en;
   logic        hold;
   logic [2:0]  ra_addr;
   logic [2:0]  rb_addr;
   logic [7:0]  ra_data;
   logic [7:0]  rb_data;
   logic        zero_flag;
   logic        sign_flag;
   logic        wb_valid;
   logic [15:0] retire_cnt;

   int checks = 0;
   int errors = 0;

   alu_writeback #(.W(8), .NREG(8), .AW(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_result  (in_result),
      .in_zero    (in_zero),
      .in_sign    (in_sign),
      .in_rd      (in_rd),
      .in_wen     (in_wen),
      .in_flag_en (in_flag_en),
      .hold       (hold),
      .ra_addr    (ra_addr),
      .rb_addr    (rb_addr),
      .ra_data    (ra_data),
      .rb_data    (rb_data),
      .zero_flag  (zero_flag),
      .sign_flag  (sign_flag),
      .wb_valid   (wb_valid),
      .retire_cnt (retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [7:0]  res;
      logic        z;
      logic        s;
      logic [2:0]  rd;
      logic        wen;
      logic        fe;
      logic        hold;
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic        e_ready;
      logic [7:0]  e_ra;
      logic [7:0]  e_rb;
      logic        e_z;
      logic        e_s;
      logic        e_wbv;
      logic [15:0] e_cnt;
   } vec_t;

   localparam int NV = 23;
   vec_t tbl [NV];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      in_valid   = t.v;
      in_result  = t.res;
      in_zero    = t.z;
      in_sign    = t.s;
      in_rd      = t.rd;
      in_wen     = t.wen;
      in_flag_en = t.fe;
      hold       = t.hold;
      ra_addr    = t.ra;
      rb_addr    = t.rb;
   endtask

   initial begin
      // Each row: inputs for one cycle, outputs expected before that cycle's edge.
      //          v  res    z  s  rd wen fe hold ra rb | rdy ra     rb     z  s  wbv cnt
      tbl[0]  = '{0, 8'h00, 0, 0, 0, 0,  0, 0,   0, 3,   1, 8'h00, 8'h00, 0, 0, 0, 0};
      tbl[1]  = '{1, 8'h5A, 0, 1, 3, 1,  1, 0,   3, 3,   1, 8'h00, 8'h00, 0, 0, 0, 0};
      tbl[2]  = '{0, 8'h00, 0, 0, 0, 0,  0, 0,   3, 0,   1, 8'h5A, 8'h00, 0, 0, 1, 0};
      tbl[3]  = '{0, 8'h00, 0, 0, 0, 0,  0, 0,   3, 3,   1, 8'h5A, 8'h5A, 0, 1, 0, 1};
      tbl[4]  = '{1, 8'hFF, 0, 1, 0, 1,  0, 0,   0, 3,   1, 8'h00, 8'h5A, 0, 1, 0, 1};
      tbl[5]  = '{0, 8'h00, 0, 0, 0, 0,  0, 0,   0, 0,   1, 8'h00, 8'h00, 0, 1, 1, 1};
      tbl[6]  = '{0, 8'h00, 0, 0, 0, 0,  0, 0,   0, 3,   1, 8'h00, 8'h5A, 0, 1, 0, 2};
      tbl[7]  = '{1, 8'h11, 0, 0, 2, 1,  1, 0,   2, 2,   1, 8'h00, 8'h00, 0, 1, 0, 2};
      tbl[8]  = '{1, 8'h22, 1, 0, 2, 1,  1, 1,   2, 2,   0, 8'h11, 8'h11, 0, 1, 1, 2};
      tbl[9]  = '{1, 8'h22, 1, 0, 2, 1,  1, 1,   2, 2,   0, 8'h11, 8'h11, 0, 1, 1, 2};
      tbl[10] = '{1, 8'h22, 1, 0, 2, 1,  1, 1,   2, 2,   0, 8'h11, 8'h11, 0, 1, 1, 2};
      tbl[11] = '{1, 8'h22, 1, 0, 2, 1,  1, 0,   2, 2,   1, 8'h11, 8'h11, 0, 1, 1, 2};
      tbl[12] = '{0, 8'h00, 0, 0, 0, 0,  0, 0,   2, 2,   1, 8'h22, 8'h22, 0, 0, 1, 3};
      tbl[13] = '{0, 8'h00, 0, 0, 0, 0,  0, 0,   2, 2,   1, 8'h22, 8'h22, 1, 0, 0, 4};
      tbl[14] = '{1, 8'hA1, 0, 0, 1, 1,  0, 0,   1, 4,   1, 8'h00, 8'h00, 1, 0, 0, 4};
      tbl[15] = '{1, 8'hB2, 0, 0, 2, 1,  0, 0,   1, 2,   1, 8'hA1, 8'h22, 1, 0, 1, 4};
      tbl[16] = '{1, 8'hC3, 0, 0, 3, 1,  0, 0,   1, 2,   1, 8'hA1, 8'hB2, 1, 0, 1, 5};
      tbl[17] = '{1, 8'hD4, 0, 0, 4, 1,  0, 0,   3, 4,   1, 8'hC3, 8'h00, 1, 0, 1, 6};
      tbl[18] = '{0, 8'h00, 0, 0, 0, 0,  0, 0,   3, 4,   1, 8'hC3, 8'hD4, 1, 0, 1, 7};
      tbl[19] = '{0, 8'h00, 0, 0, 0, 0,  0, 0,   1, 2,   1, 8'hA1, 8'hB2, 1, 0, 0, 8};
      tbl[20] = '{1, 8'h77, 0, 1, 5, 0,  1, 0,   5, 4,   1, 8'h00, 8'hD4, 1, 0, 0, 8};
      tbl[21] = '{0, 8'h00, 0, 0, 0, 0,  0, 0,   5, 5,   1, 8'h00, 8'h00, 1, 0, 1, 8};
      tbl[22] = '{0, 8'h00, 0, 0, 0, 0,  0, 0,   5, 0,   1, 8'h00, 8'h00, 0, 1, 0, 9};

      rst_n = 1'b0;
      drive(tbl[0]);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         drive(tbl[i]);
         @(negedge clk);
         chk($sformatf("v%0d in_ready", i),   int'(in_ready),   int'(tbl[i].e_ready));
         chk($sformatf("v%0d ra_data", i),    int'(ra_data),    int'(tbl[i].e_ra));
         chk($sformatf("v%0d rb_data", i),    int'(rb_data),    int'(tbl[i].e_rb));
         chk($sformatf("v%0d zero_flag", i),  int'(zero_flag),  int'(tbl[i].e_z));
         chk($sformatf("v%0d sign_flag", i),  int'(sign_flag),  int'(tbl[i].e_s));
         chk($sformatf("v%0d wb_valid", i),   int'(wb_valid),   int'(tbl[i].e_wbv));
         chk($sformatf("v%0d retire_cnt", i), int'(retire_cnt), int'(tbl[i].e_cnt));
         @(posedge clk);
         #1;
      end

      // Asynchronous reset while an entry is stalled under hold.
      in_valid = 1'b1; in_result = 8'h33; in_zero = 1'b1; in_sign = 1'b1;
      in_rd = 3'd6; in_wen = 1'b1; in_flag_en = 1'b1; hold = 1'b0;
      ra_addr = 3'd6; rb_addr = 3'd1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      hold = 1'b1;
      #1;
      chk("stall wb_valid", int'(wb_valid), 1);
      chk("stall bypass r6", int'(ra_data), 'h33);
      chk("stall in_ready", int'(in_ready), 0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst wb_valid", int'(wb_valid), 0);
      chk("arst ra r6", int'(ra_data), 0);
      chk("arst rb r1", int'(rb_data), 0);
      chk("arst zero_flag", int'(zero_flag), 0);
      chk("arst sign_flag", int'(sign_flag), 0);
      chk("arst retire_cnt", int'(retire_cnt), 0);
      chk("arst in_ready", int'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      hold = 1'b0;
      @(posedge clk);
      #1;
      chk("post-rst r6", int'(ra_data), 0);
      chk("post-rst retire_cnt", int'(retire_cnt), 0);
      chk("post-rst sign_flag", int'(sign_flag), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Stage directly downstream of the 8-bit ALU.
- Captures the ALU result and its Zero/Sign flags into a one-entry writeback register, then commits them to an 8-entry register file and a flag register.
- The register file's two combinational read ports drive the ALU A/B operands, with bypass from the pending writeback entry.
- Valid/ready handshake on the input plus a downstream hold input allow stalls without losing results.

Parameters:
- W, 8, data width; matches the ALU width.
- NREG, 8, number of registers.
- AW, 3, register address width; NREG must equal 2**AW.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ALU result presented this cycle.
- in_ready  output  1  stage can accept the input this cycle.
- in_result  input  W  ALU out.
- in_zero  input  1  ALU Zero.
- in_sign  input  1  ALU Sign.
- in_rd  input  AW  destination register.
- in_wen  input  1  write in_result to in_rd on commit.
- in_flag_en  input  1  update flags on commit.
- hold  input  1  downstream stall; blocks commit.
- ra_addr  input  AW  read port A address.
- rb_addr  input  AW  read port B address.
- ra_data  output  W  operand A to the ALU.
- rb_data  output  W  operand B to the ALU.
- zero_flag  output  1  committed Zero flag.
- sign_flag  output  1  committed Sign flag.
- wb_valid  output  1  writeback register occupied.
- retire_cnt  output  16  count of committed entries.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers clear to 0.
  - wb_valid=0, zero_flag=0, sign_flag=0, retire_cnt=0.
  - in_ready=1 after reset; it is combinational from wb_valid and hold.
  - Reset mid-stall discards the pending entry without committing it.
- Accept:
  - in_ready = !wb_valid | !hold.
  - When in_valid & in_ready at a clock edge, the WB register loads {result, zero, sign, rd, wen, flag_en} and wb_valid=1.
  - in_valid with in_ready=0: input is ignored. The upstream must hold its values stable.
- Commit:
  - Occurs at a clock edge when wb_valid & !hold.
  - If wen and rd!=0: reg[rd] <= result.
  - If flag_en: zero_flag <= zero, sign_flag <= sign.
  - retire_cnt increments by 1, wrapping 0xFFFF -> 0x0000. The count includes entries with wen=0.
  - wb_valid is cleared unless a new accept happens on the same edge; in that case it stays 1 with the new contents.
- Latency:
  - Result is accepted at edge N and committed at edge N+1 if hold=0.
  - Visible in the register file from cycle N+1 via bypass, and from the array after edge N+1.
- Register 0: writes are dropped; reads always return 0, including through bypass.
- Reads:
  - Combinational.
  - If wb_valid & wen & rd==addr & addr!=0, data = WB result (bypass). Otherwise data = reg[addr].
  - Both ports may bypass simultaneously.
- Hold:
  - While hold=1 and wb_valid=1: no commit, in_ready=0, flags and registers frozen.
  - The bypass stays active, so the ALU still sees the pending value.
- Throughput: with hold=0, one entry per cycle back-to-back.
- Width: no arithmetic on data, except the 16-bit retire_cnt add with modulo wrap.

Test Plan:
- Reset then idle -> ra_data=rb_data=0, flags 0, in_ready=1, retire_cnt=0.
- Accept result=0x5A, rd=3, wen=1, flag_en=1, zero=0, sign=1 with ra_addr=3:
  - Next cycle ra_data=0x5A via bypass.
  - After the following edge reg3=0x5A, sign_flag=1, retire_cnt=1.
- Write 0xFF to rd=0 -> ra_addr=0 reads 0 in both the bypass and committed cycles; retire_cnt still increments.
- Accept 0x11 to r2, then assert hold for 3 cycles while presenting 0x22 to r2:
  - in_ready=0 during hold; r2 array stays 0 and rb_data(r2)=0x11.
  - Release hold -> 0x11 commits, then 0x22 is accepted and commits; final r2=0x22.
- Back-to-back 4 results to r1..r4 with hold=0 -> one per cycle, in_ready stays 1, retire_cnt=4.
- Assert rst_n low while wb_valid=1 under hold -> entry is discarded, registers and flags are 0, wb_valid=0 immediately (asynchronous).
